// File: rtl/sd_ctrl.sv
// sd_ctrl: sequencing controller for the synaptic-dendrite accumulator.
// Issues axon events as read-modify-write accumulations with a one-cycle
// bubble on back-to-back same-neuron hits. Arbitrates host vm/weight
// accesses against axon traffic with a starvation limit. Runs the per-tick
// drain / bank-swap / read-clear sweep over the ping-pong vm buffer.
module sd_ctrl #(
  parameter int NNW        = 12,
  parameter int WD         = 6,
  parameter int VW         = 20,
  parameter int WW         = 16,
  parameter int LAN_num    = 2,
  parameter int NEURON_NUM = 4096,
  parameter int HOST_WAIT  = 16
) (
  input  logic               clk_SD,
  input  logic               rst,
  // axon events
  input  logic               ev_vld,
  output logic               ev_rdy,
  input  logic [NNW-1:0]     ev_vm_addr,
  input  logic [WD-1:0]      ev_wgt_addr,
  input  logic [LAN_num-1:0] ev_lans,
  // tick control
  input  logic               tick_req,
  input  logic               tick_clear_only,
  output logic               tick_busy,
  output logic               tick_done,
  // host access
  input  logic               host_req,
  output logic               host_gnt,
  input  logic               host_we,
  input  logic               host_sel,
  input  logic [NNW-1:0]     host_addr,
  input  logic [VW-1:0]      host_wdata,
  output logic               host_rvld,
  output logic [VW-1:0]      host_rdata,
  // axon path to sd
  output logic               axon_sd_vld,
  output logic [NNW-1:0]     axon_sd_vm_addr,
  output logic [WD-1:0]      axon_sd_wgt_addr,
  output logic [LAN_num-1:0] axon_sd_lans,
  // sweep / config path to sd
  output logic               config_sd_vld,
  output logic               config_sd_clear,
  output logic               config_sd_start,
  output logic [NNW-1:0]     config_sd_vm_addr,
  output logic               config_sd_vm_we,
  output logic [NNW-1:0]     config_sd_vm_waddr,
  output logic [VW-1:0]      config_sd_vm_wdata,
  output logic               config_sd_vm_re,
  output logic [NNW-1:0]     config_sd_vm_raddr,
  output logic               config_sd_wgt_we,
  output logic [WD-1:0]      config_sd_wgt_waddr,
  output logic [WW-1:0]      config_sd_wgt_wdata,
  output logic               config_sd_wgt_re,
  output logic [WD-1:0]      config_sd_wgt_raddr,
  input  logic [VW-1:0]      config_sd_vm_rdata,
  input  logic [WW-1:0]      config_sd_wgt_rdata,
  // soma qualifier
  output logic               soma_vld,
  output logic [NNW-1:0]     soma_addr
);

  localparam int WCW = (HOST_WAIT < 1) ? 1 : $clog2(HOST_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIM  = WCW'(HOST_WAIT);
  localparam logic [NNW-1:0] LAST_ADDR = NNW'(NEURON_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_START = 3'd2,
    S_SWEEP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [NNW-1:0]   cnt;
  logic [NNW-1:0]   cnt_nxt;
  logic             clear_only;
  logic             clear_only_nxt;

  logic             fsm_block;
  logic             sweep_vld;
  logic             start_pulse;
  logic             done_pulse;
  logic             busy;

  logic             last_vld;
  logic [NNW-1:0]   last_addr;
  logic [WCW-1:0]   wait_cnt;
  logic [WCW-1:0]   wait_nxt;
  logic             hazard;
  logic             starve;
  logic             issue;
  logic             gnt;
  logic             vm_wr_req;

  logic             rd_pend;
  logic             rd_sel;

  // Tick sequencer: next state, sweep counter and per-state decodes.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    clear_only_nxt = clear_only;
    fsm_block      = 1'b0;
    sweep_vld      = 1'b0;
    start_pulse    = 1'b0;
    done_pulse     = 1'b0;
    busy           = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick_req) begin
          state_nxt      = S_DRAIN;
          clear_only_nxt = tick_clear_only;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        busy      = 1'b1;
        fsm_block = 1'b1;
        // Wait for the write-back of an event issued last cycle.
        if (!last_vld) begin
          state_nxt = S_START;
        end else begin
          state_nxt = S_DRAIN;
        end
      end
      S_START: begin
        busy        = 1'b1;
        fsm_block   = 1'b1;
        start_pulse = 1'b1;
        cnt_nxt     = {NNW{1'b0}};
        state_nxt   = S_SWEEP;
      end
      S_SWEEP: begin
        busy      = 1'b1;
        sweep_vld = 1'b1;
        if (cnt == LAST_ADDR) begin
          cnt_nxt   = {NNW{1'b0}};
          state_nxt = S_DONE;
        end else begin
          cnt_nxt   = cnt + {{(NNW-1){1'b0}}, 1'b1};
          state_nxt = S_SWEEP;
        end
      end
      S_DONE: begin
        done_pulse = 1'b1;
        // Busy is already low here, so a new request starts a fresh tick.
        if (tick_req) begin
          state_nxt      = S_DRAIN;
          clear_only_nxt = tick_clear_only;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt      = S_IDLE;
        cnt_nxt        = {NNW{1'b0}};
        clear_only_nxt = 1'b0;
      end
    endcase
  end

  // Tick sequencer state, sweep counter and latched clear-only mode.
  always_ff @(posedge clk_SD) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= {NNW{1'b0}};
      clear_only <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      clear_only <= clear_only_nxt;
    end
  end

  // Event acceptance and host grant; events win, host is protected from
  // starvation by stealing one event slot when the wait limit is reached.
  always_comb begin
    hazard    = last_vld & (ev_vm_addr == last_addr);
    starve    = (wait_cnt == WAIT_LIM);
    ev_rdy    = ~rst & ~fsm_block & ~hazard & ~starve;
    issue     = ev_vld & ev_rdy;
    vm_wr_req = host_we & ~host_sel;
    // A vm write collides with the sd write-back port when last_vld is set.
    gnt       = ~rst & host_req & ~issue & ~(vm_wr_req & last_vld);
    host_gnt  = gnt;
    if (host_req & ~gnt) begin
      if (starve) begin
        wait_nxt = {WCW{1'b0}};
      end else begin
        wait_nxt = wait_cnt + {{(WCW-1){1'b0}}, 1'b1};
      end
    end else begin
      wait_nxt = {WCW{1'b0}};
    end
  end

  // Record the issue of cycle t so cycle t+1 can see the pending write-back.
  always_ff @(posedge clk_SD) begin
    if (rst) begin
      last_vld  <= 1'b0;
      last_addr <= {NNW{1'b0}};
      wait_cnt  <= {WCW{1'b0}};
    end else begin
      last_vld  <= issue;
      last_addr <= issue ? ev_vm_addr : last_addr;
      wait_cnt  <= wait_nxt;
    end
  end

  // Host read pending flag and memory select, one cycle behind the grant.
  always_ff @(posedge clk_SD) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_sel  <= 1'b0;
    end else begin
      rd_pend <= gnt & ~host_we;
      rd_sel  <= gnt ? host_sel : rd_sel;
    end
  end

  // Soma qualifier aligned with the sd read data one cycle after the sweep.
  always_ff @(posedge clk_SD) begin
    if (rst) begin
      soma_vld  <= 1'b0;
      soma_addr <= {NNW{1'b0}};
    end else begin
      soma_vld  <= sweep_vld & ~clear_only;
      soma_addr <= sweep_vld ? cnt : {NNW{1'b0}};
    end
  end

  // Drive the sd ports; address/data are zero whenever their strobe is low.
  always_comb begin
    axon_sd_vld      = issue;
    axon_sd_vm_addr  = issue ? ev_vm_addr  : {NNW{1'b0}};
    axon_sd_wgt_addr = issue ? ev_wgt_addr : {WD{1'b0}};
    axon_sd_lans     = issue ? ev_lans     : {LAN_num{1'b0}};

    config_sd_vld     = sweep_vld;
    config_sd_clear   = sweep_vld & clear_only;
    config_sd_start   = start_pulse;
    config_sd_vm_addr = sweep_vld ? cnt : {NNW{1'b0}};

    config_sd_vm_we    = gnt & vm_wr_req;
    config_sd_vm_waddr = config_sd_vm_we ? host_addr  : {NNW{1'b0}};
    config_sd_vm_wdata = config_sd_vm_we ? host_wdata : {VW{1'b0}};
    config_sd_vm_re    = gnt & ~host_we & ~host_sel;
    config_sd_vm_raddr = config_sd_vm_re ? host_addr  : {NNW{1'b0}};

    config_sd_wgt_we    = gnt & host_we & host_sel;
    config_sd_wgt_waddr = config_sd_wgt_we ? host_addr[WD-1:0]  : {WD{1'b0}};
    config_sd_wgt_wdata = config_sd_wgt_we ? host_wdata[WW-1:0] : {WW{1'b0}};
    config_sd_wgt_re    = gnt & ~host_we & host_sel;
    config_sd_wgt_raddr = config_sd_wgt_re ? host_addr[WD-1:0]  : {WD{1'b0}};

    tick_busy = busy;
    tick_done = done_pulse;
    host_rvld = rd_pend;
    if (rd_pend) begin
      if (rd_sel) begin
        host_rdata = VW'(config_sd_wgt_rdata);
      end else begin
        host_rdata = config_sd_vm_rdata;
      end
    end else begin
      host_rdata = {VW{1'b0}};
    end
  end

endmodule

// File: tb/tb_sd_ctrl.sv
// Scoreboard bench for sd_ctrl with a small behavioural sd memory stub.
module tb_sd_ctrl;
  localparam int NNW = 12, WD = 6, VW = 20, WW = 16, LN = 2, NN = 8, HW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ev_vld, ev_rdy, tick_req, tick_clear_only, tick_busy, tick_done;
  logic [NNW-1:0] ev_vm_addr, host_addr, axon_sd_vm_addr, config_sd_vm_addr;
  logic [WD-1:0]  ev_wgt_addr, axon_sd_wgt_addr;
  logic [LN-1:0]  ev_lans, axon_sd_lans;
  logic host_req, host_gnt, host_we, host_sel, host_rvld;
  logic [VW-1:0]  host_wdata, host_rdata;
  logic axon_sd_vld, config_sd_vld, config_sd_clear, config_sd_start;
  logic config_sd_vm_we, config_sd_vm_re, config_sd_wgt_we, config_sd_wgt_re;
  logic [NNW-1:0] config_sd_vm_waddr, config_sd_vm_raddr, soma_addr;
  logic [VW-1:0]  config_sd_vm_wdata, config_sd_vm_rdata;
  logic [WD-1:0]  config_sd_wgt_waddr, config_sd_wgt_raddr;
  logic [WW-1:0]  config_sd_wgt_wdata, config_sd_wgt_rdata;
  logic soma_vld;

  sd_ctrl #(.NNW(NNW), .WD(WD), .VW(VW), .WW(WW), .LAN_num(LN),
            .NEURON_NUM(NN), .HOST_WAIT(HW)) dut (
    .clk_SD(clk), .rst(rst),
    .ev_vld(ev_vld), .ev_rdy(ev_rdy), .ev_vm_addr(ev_vm_addr),
    .ev_wgt_addr(ev_wgt_addr), .ev_lans(ev_lans),
    .tick_req(tick_req), .tick_clear_only(tick_clear_only),
    .tick_busy(tick_busy), .tick_done(tick_done),
    .host_req(host_req), .host_gnt(host_gnt), .host_we(host_we),
    .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rvld(host_rvld), .host_rdata(host_rdata),
    .axon_sd_vld(axon_sd_vld), .axon_sd_vm_addr(axon_sd_vm_addr),
    .axon_sd_wgt_addr(axon_sd_wgt_addr), .axon_sd_lans(axon_sd_lans),
    .config_sd_vld(config_sd_vld), .config_sd_clear(config_sd_clear),
    .config_sd_start(config_sd_start), .config_sd_vm_addr(config_sd_vm_addr),
    .config_sd_vm_we(config_sd_vm_we), .config_sd_vm_waddr(config_sd_vm_waddr),
    .config_sd_vm_wdata(config_sd_vm_wdata), .config_sd_vm_re(config_sd_vm_re),
    .config_sd_vm_raddr(config_sd_vm_raddr), .config_sd_wgt_we(config_sd_wgt_we),
    .config_sd_wgt_waddr(config_sd_wgt_waddr), .config_sd_wgt_wdata(config_sd_wgt_wdata),
    .config_sd_wgt_re(config_sd_wgt_re), .config_sd_wgt_raddr(config_sd_wgt_raddr),
    .config_sd_vm_rdata(config_sd_vm_rdata), .config_sd_wgt_rdata(config_sd_wgt_rdata),
    .soma_vld(soma_vld), .soma_addr(soma_addr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // ---------------- sd memory stub (read at issue, write back one cycle later)
  logic [VW-1:0] vm_mem [0:4095];
  logic [WW-1:0] wgt_mem [0:63];
  logic          pend_vld = 1'b0;
  logic [NNW-1:0] pend_addr;
  logic [VW-1:0] pend_val;

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 4096; i++) vm_mem[i] <= '0;
      for (int i = 0; i < 64; i++) wgt_mem[i] <= '0;
      pend_vld <= 1'b0;
    end else begin
      if (config_sd_vm_we) vm_mem[config_sd_vm_waddr] <= config_sd_vm_wdata;
      if (config_sd_wgt_we) wgt_mem[config_sd_wgt_waddr] <= config_sd_wgt_wdata;
      // write-back port overrides a colliding host write
      if (pend_vld) vm_mem[pend_addr] <= pend_val;
      if (config_sd_vld && config_sd_clear) vm_mem[config_sd_vm_addr] <= '0;
      if (config_sd_vm_re)
        config_sd_vm_rdata <= (pend_vld && pend_addr == config_sd_vm_raddr) ? pend_val
                                                                            : vm_mem[config_sd_vm_raddr];
      if (config_sd_wgt_re) config_sd_wgt_rdata <= wgt_mem[config_sd_wgt_raddr];
      pend_vld  <= axon_sd_vld;
      pend_addr <= axon_sd_vm_addr;
      pend_val  <= vm_mem[axon_sd_vm_addr] + VW'(wgt_mem[axon_sd_wgt_addr]);
    end
  end

  // ---------------- reference model and scoreboard queues
  logic [VW-1:0] exp_vm [0:4095];
  logic [WW-1:0] exp_wgt [0:63];

  typedef struct packed { logic [NNW-1:0] a; logic [WD-1:0] w; logic [LN-1:0] l; } ev_t;
  typedef struct packed { logic [31:0] cyc; logic [VW-1:0] d; } rd_t;
  typedef struct packed { logic [31:0] cyc; logic [NNW-1:0] a; } soma_t;
  ev_t   ev_q[$];
  rd_t   rd_q[$];
  soma_t soma_q[$];
  int    start_q[$];
  int    done_q[$];

  ev_t   m_e;
  rd_t   m_r;
  soma_t m_s;
  int    m_c;

  // Monitor: pops an expectation whenever the DUT presents an output.
  always @(negedge clk) begin
    if (mon_en) begin
      if (axon_sd_vld) begin
        if (ev_q.size() == 0) bad("axon_sd_vld_unexpected");
        else begin
          m_e = ev_q.pop_front();
          chk("axon_vm_addr", axon_sd_vm_addr, m_e.a);
          chk("axon_wgt_addr", axon_sd_wgt_addr, m_e.w);
          chk("axon_lans", axon_sd_lans, m_e.l);
        end
      end
      if (host_rvld) begin
        if (rd_q.size() == 0) bad("host_rvld_unexpected");
        else begin
          m_r = rd_q.pop_front();
          chk("host_rvld_cycle", cyc, m_r.cyc);
          chk("host_rdata", host_rdata, m_r.d);
        end
      end
      if (soma_vld) begin
        if (soma_q.size() == 0) bad("soma_vld_unexpected");
        else begin
          m_s = soma_q.pop_front();
          chk("soma_cycle", cyc, m_s.cyc);
          chk("soma_addr", soma_addr, m_s.a);
        end
      end
      if (config_sd_start) begin
        if (start_q.size() == 0) bad("config_sd_start_unexpected");
        else begin
          m_c = start_q.pop_front();
          chk("start_cycle", cyc, m_c);
        end
      end
      if (tick_done) begin
        if (done_q.size() == 0) bad("tick_done_unexpected");
        else begin
          m_c = done_q.pop_front();
          chk("tick_done_cycle", cyc, m_c);
        end
      end
    end
  end

  // ---------------- stimulus tasks (start and end at posedge + 1)
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_ev(input logic [NNW-1:0] a, input logic [WD-1:0] w,
                         input logic [LN-1:0] l, output int tries);
    ev_t e;
    bit acc;
    e.a = a; e.w = w; e.l = l;
    ev_q.push_back(e);
    ev_vld = 1'b1; ev_vm_addr = a; ev_wgt_addr = w; ev_lans = l;
    tries = 0; acc = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tries++;
      @(negedge clk); acc = ev_rdy;
      @(posedge clk); #1;
      if (acc) break;
    end
    ev_vld = 1'b0;
    if (acc) exp_vm[a] = exp_vm[a] + VW'(exp_wgt[w]);
    else bad("ev_accept_timeout");
  endtask

  task automatic host_op(input bit sel, input bit we, input logic [NNW-1:0] a,
                         input logic [VW-1:0] d, output int lat);
    bit g;
    rd_t r;
    host_req = 1'b1; host_sel = sel; host_we = we; host_addr = a; host_wdata = d;
    lat = 0; g = 1'b0;
    for (int k = 0; k < 40 && !g; k++) begin
      lat++;
      @(negedge clk); g = host_gnt;
      if (g) begin
        if (!we) begin
          r.cyc = 32'(cyc + 1);
          r.d = sel ? VW'(exp_wgt[a[WD-1:0]]) : exp_vm[a];
          rd_q.push_back(r);
        end else if (sel) exp_wgt[a[WD-1:0]] = d[WW-1:0];
        else exp_vm[a] = d;
      end
      @(posedge clk); #1;
    end
    host_req = 1'b0; host_we = 1'b0;
    if (!g) bad("host_gnt_timeout");
  endtask

  task automatic do_tick(input bit clr, input bit with_ev, input logic [NNW-1:0] ea);
    int c, x;
    bit acc;
    ev_t e;
    soma_t s;
    c = cyc; x = with_ev ? 1 : 0;
    tick_req = 1'b1; tick_clear_only = clr;
    if (with_ev) begin
      e.a = ea; e.w = 6'd1; e.l = 2'd2; ev_q.push_back(e);
      ev_vld = 1'b1; ev_vm_addr = ea; ev_wgt_addr = 6'd1; ev_lans = 2'd2;
    end
    start_q.push_back(c + 2 + x);
    done_q.push_back(c + NN + 3 + x);
    if (!clr) for (int i = 0; i < NN; i++) begin
      s.cyc = 32'(c + 4 + x + i); s.a = NNW'(i); soma_q.push_back(s);
    end
    @(negedge clk); acc = ev_rdy;
    if (with_ev) begin
      chk("tick_ev_accept", acc, 1);
      if (acc) exp_vm[ea] = exp_vm[ea] + VW'(exp_wgt[1]);
    end
    @(posedge clk); #1;
    tick_req = 1'b0; ev_vld = 1'b0;
    for (int k = 1; k <= NN + 3 + x; k++) begin
      tick_req = (k == 6);  // request during busy must be ignored
      @(negedge clk);
      if (k == 1) begin
        chk("drain_ev_rdy", ev_rdy, 0);
        chk("drain_busy", tick_busy, 1);
      end
      if (k == 5 + x) chk("sweep_ev_rdy", ev_rdy, 1);
      @(posedge clk); #1;
    end
    tick_req = 1'b0;
    @(negedge clk); chk("after_tick_busy", tick_busy, 0);
    @(posedge clk); #1;
    if (clr) for (int i = 0; i < NN; i++) exp_vm[i] = '0;
  endtask

  // ---------------- main sequence
  int t0, t1, t2, lat, c0, rr;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) exp_vm[i] = '0;
    for (int i = 0; i < 64; i++) exp_wgt[i] = '0;
    rst = 1'b1; ev_vld = 1'b0; ev_vm_addr = '0; ev_wgt_addr = '0; ev_lans = '0;
    tick_req = 1'b0; tick_clear_only = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_sel = 1'b0; host_addr = '0; host_wdata = '0;
    step(2);
    // requests during reset must not leak through
    ev_vld = 1'b1; host_req = 1'b1;
    @(negedge clk);
    chk("rst_ev_rdy", ev_rdy, 0);
    chk("rst_axon_vld", axon_sd_vld, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_busy", tick_busy, 0);
    chk("rst_cfg_vld", config_sd_vld, 0);
    chk("rst_soma_vld", soma_vld, 0);
    chk("rst_host_rvld", host_rvld, 0);
    @(posedge clk); #1;
    rst = 1'b0; ev_vld = 1'b0; host_req = 1'b0; mon_en = 1'b1;
    @(negedge clk); chk("first_ev_rdy", ev_rdy, 1);
    @(posedge clk); #1;

    // weight table
    for (int i = 0; i < 64; i++) begin
      host_op(1'b1, 1'b1, NNW'(i), VW'($urandom_range(0, 255)), lat);
      if (i == 0) chk("wgt_write_lat", lat, 1);
    end
    host_op(1'b1, 1'b1, 12'd3, 20'd10, lat);
    host_op(1'b1, 1'b0, 12'd3, 20'd0, lat);
    chk("wgt_read_lat", lat, 1);

    // same-address back-to-back: ev_rdy 1,0,1,0,1
    send_ev(12'd5, 6'd3, 2'd1, t0);
    send_ev(12'd5, 6'd3, 2'd2, t1);
    send_ev(12'd5, 6'd3, 2'd3, t2);
    chk("hazard_tries0", t0, 1);
    chk("hazard_tries1", t1, 2);
    chk("hazard_tries2", t2, 2);
    host_op(1'b0, 1'b0, 12'd5, 20'd0, lat);
    chk("vm5_model", exp_vm[5], 30);

    // distinct addresses: no bubbles
    c0 = cyc;
    send_ev(12'd1, 6'd7, 2'd0, t0);
    send_ev(12'd2, 6'd8, 2'd1, t1);
    send_ev(12'd3, 6'd9, 2'd2, t2);
    chk("nobub_tries", t0 + t1 + t2, 3);
    chk("nobub_cycles", cyc - c0, 3);

    // vm write right after an issue waits for the write-back slot
    send_ev(12'd9, 6'd4, 2'd0, t0);
    host_op(1'b0, 1'b1, 12'd9, 20'h1234, lat);
    chk("vm_write_after_issue_lat", lat, 2);
    host_op(1'b0, 1'b0, 12'd9, 20'd0, lat);

    // host starvation under continuous distinct events
    fork
      begin
        for (int i = 0; i < 40; i++) send_ev(NNW'(16 + (i % 8)), WD'(i), LN'(i), t0);
      end
      begin
        step(3);
        host_op(1'b0, 1'b0, 12'd7, 20'd0, lat);
        chk("starve_grant_lat", lat, HW + 1);
      end
    join

    // randomized mix
    for (int n = 0; n < 120; n++) begin
      rr = $urandom_range(0, 9);
      if (rr < 7) send_ev(NNW'($urandom_range(0, 15)), WD'($urandom_range(0, 63)),
                          LN'($urandom_range(0, 3)), t0);
      else if (rr == 7) step(1);
      else if (rr == 8) host_op(1'b0, 1'b0, NNW'($urandom_range(0, 15)), 20'd0, lat);
      else host_op(1'b0, 1'b1, NNW'($urandom_range(0, 15)), VW'($urandom), lat);
    end
    for (int i = 0; i < 24; i++) host_op(1'b0, 1'b0, NNW'(i), 20'd0, lat);

    // ticks
    do_tick(1'b0, 1'b0, 12'd0);
    do_tick(1'b0, 1'b1, 12'd30);
    do_tick(1'b1, 1'b0, 12'd0);
    for (int i = 0; i < 10; i++) host_op(1'b0, 1'b0, NNW'(i), 20'd0, lat);

    // reset in the middle of a sweep
    c0 = cyc;
    tick_req = 1'b1; tick_clear_only = 1'b0;
    start_q.push_back(c0 + 2);
    for (int i = 0; i < 3; i++) begin
      m_s.cyc = 32'(c0 + 4 + i); m_s.a = NNW'(i); soma_q.push_back(m_s);
    end
    step(1);
    tick_req = 1'b0;
    step(5);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_sweep_addr", config_sd_vm_addr, 3);
    chk("rst_sweep_vld", config_sd_vld, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", tick_busy, 0);
    chk("post_rst_cfg_vld", config_sd_vld, 0);
    chk("post_rst_soma_vld", soma_vld, 0);
    chk("post_rst_done", tick_done, 0);
    chk("post_rst_start", config_sd_start, 0);
    chk("post_rst_ev_rdy", ev_rdy, 1);
    @(posedge clk); #1;
    step(14);
    do_tick(1'b0, 1'b0, 12'd0);

    step(4);
    chk("ev_q_empty", ev_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("soma_q_empty", soma_q.size(), 0);
    chk("start_q_empty", start_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_ctrl.md
# sd_ctrl

Controller that sequences the synaptic-dendrite accumulator (`sd`) in a neuron node. It accepts axon events over a valid/ready handshake and issues them as read-modify-write accumulations, inserting bubbles for back-to-back same-address hazards. It arbitrates host configuration accesses to the vm and weight memories against axon traffic. It runs the per-tick bank swap and the soma read/clear sweep of the ping-pong vm buffer.

## Interface
- NNW, 12, neuron address width
- WD, 6, weight address width
- VW, 20, vm width
- WW, 16, weight width
- LAN_num, 2, lane field width
- NEURON_NUM, 4096, neurons swept per tick (≤ 2^NNW)
- HOST_WAIT, 16, host starvation limit in cycles
- clk_SD  in  1  single clock
- rst  in  1  synchronous, active-high reset
- ev_vld / ev_rdy  in / out  1 / 1  axon event handshake
- ev_vm_addr  in  NNW  target neuron
- ev_wgt_addr  in  WD  weight index
- ev_lans  in  LAN_num  lane field, passed through
- tick_req  in  1  start-of-tick pulse
- tick_clear_only  in  1  sampled with tick_req; 1 = clear without soma read
- tick_busy  out  1  tick sequence in progress
- tick_done  out  1  one-cycle pulse at sweep end
- host_req / host_gnt  in / out  1 / 1  host access; transfer happens when both are 1
- host_we, host_sel  in  1, 1  write enable; sel 0 = vm, 1 = weight
- host_addr  in  NNW  address; weight uses [WD-1:0]
- host_wdata  in  VW  write data; weight uses [WW-1:0]
- host_rvld  out  1  read data valid
- host_rdata  out  VW  read data; weight zero-extended
- axon_sd_vld, axon_sd_vm_addr, axon_sd_wgt_addr, axon_sd_lans  out  to sd
- config_sd_vld, config_sd_clear, config_sd_start, config_sd_vm_addr  out  to sd
- config_sd_vm_we/waddr/wdata, config_sd_vm_re/raddr  out  to sd
- config_sd_wgt_we/waddr/wdata, config_sd_wgt_re/raddr  out  to sd
- config_sd_vm_rdata  in  VW  from sd
- config_sd_wgt_rdata  in  WW  from sd
- soma_vld / soma_addr  out  1 / NNW  qualifies sd_soma_vm

## Operation
- **Event issue.**
  - axon_sd_vld = ev_vld & ev_rdy. Addresses and lanes pass through combinationally, zero latency.
  - sd reads at issue cycle t and writes back at t+1.
  - Registered last_vld/last_addr record the issue at t.
- **Hazard.** ev_rdy = 0 at t+1 when last_vld and ev_vm_addr == last_addr. This inserts exactly one bubble.
- **ev_rdy = 0** in any of these conditions:
  - state DRAIN or START
  - hazard
  - starvation slot (see host arbitration)
- **Host arbitration.** Events have priority.
  - host_gnt = host_req & !axon_sd_vld.
  - A vm write additionally requires !last_vld (the write-back port is busy in that case).
  - A wait counter increments while host_req & !host_gnt. At HOST_WAIT it forces ev_rdy = 0 for one cycle, then clears.
  - Reads: drive *_re/raddr in the grant cycle. host_rvld pulses the next cycle, with host_rdata muxed by the registered sel.
- **Tick FSM.**
  - IDLE: tick_req → DRAIN. Latch tick_clear_only. Set tick_busy.
  - DRAIN: ev_rdy = 0. When !last_vld → START.
  - START: config_sd_start = 1 for one cycle. ev_rdy = 0. → SWEEP with counter = 0.
  - SWEEP: each cycle config_sd_vld = 1, config_sd_vm_addr = counter, config_sd_clear = latched clear_only. Counter increments. Events are accepted (they target the other bank). At counter == NEURON_NUM-1 → DONE.
  - DONE: tick_done = 1. tick_busy drops. → IDLE.
- tick_req while tick_busy is ignored.
- **Soma.** soma_vld and soma_addr register config_sd_vld & !config_sd_clear and the address, aligning with sd_soma_vm one cycle later.

## Timing
- Reset: all outputs 0, FSM IDLE, counters 0, last_vld 0.
- ev_rdy is 1 from the first cycle after reset deassertion.
- rst mid-sweep: sweep aborts, no tick_done. rst mid-read: no host_rvld.
- Tick length from tick_req to tick_done: 1 (DRAIN, if no issue in flight) + 1 (START) + NEURON_NUM + 1 cycles. DRAIN adds one more cycle if an event issued in the tick_req cycle.
- The final soma_vld appears in the DONE cycle.
- Host latency: grant → rdata at +1. Write takes effect at the grant edge.
- tick_req in the same cycle as an event issue: the event is accepted and DRAIN waits for its write-back.

## Test plan
- Events to addr 5, wgt 3, weight 10, on 3 consecutive cycles → ev_rdy pattern 1,0,1,0,1. Bank vm[5] = 30 read by host.
- Events to addresses 1,2,3 back to back → no bubbles, 3 accepts in 3 cycles.
- Host vm read of addr 7 with continuous distinct events, HOST_WAIT = 16 → grant within 17 cycles, host_rvld next cycle.
- tick_req, NEURON_NUM = 8, tick_clear_only = 0 → config_sd_start one pulse. soma_vld on 8 consecutive cycles, soma_addr 0..7. tick_done 11 cycles after tick_req.
- Repeat with tick_clear_only = 1 → no soma_vld, vm bank reads all zero afterwards. A tick_req during busy is ignored.
- rst asserted at sweep address 3 → next cycle all outputs 0, no tick_done. A new tick_req runs a full sweep.
